// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU operation classes and the datapath mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD     = 2'b00,
    ALUOP_SUB     = 2'b01,
    ALUOP_FUNCT   = 2'b10,
    ALUOP_FUNCT_I = 2'b11
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields onto the ALU control code.
module alu_decoder
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  // Immediate forms never subtract: funct7b5 there is an immediate bit, not an opcode bit.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000: alu_control = (alu_op == ALUOP_FUNCT && op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM sequencing fetch, decode, execute, memory and writeback
// for the RV32I datapath; Moore outputs with a few MemReady/Zero-gated enables.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       IllegalInstr,
  output logic [3:0] StateOut
);

  state_t  state, next_state;
  alu_op_t alu_op;
  logic    pc_write, ir_write, mem_write, reg_write, illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write   = MemReady;
        pc_write   = MemReady;
        next_state = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          default: begin
            next_state = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        next_state = MemReady ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT_I;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write   = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? ~Zero : 1'b0;
        next_state = FETCH;
      end
      JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  // The immediate type depends only on op, so it is valid in every state.
  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  // Gating with reset keeps FETCH's MemReady-driven enables quiet while reset is held.
  assign PCWrite      = reset & pc_write;
  assign IRWrite      = reset & ir_write;
  assign MemWrite     = reset & mem_write;
  assign RegWrite     = reset & reg_write;
  assign IllegalInstr = reset & illegal;
  assign StateOut     = state;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected control words are
// queued as stimulus is planned and popped against the DUT on each falling edge.
module tb_mc_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl, StateOut;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mw, rw;
    logic [1:0] rs, asa, asb, imm;
    logic [3:0] alu;
    logic       ill, adr;
  } exp_t;

  exp_t exp_q[$];
  logic rdy_q[$];
  exp_t obs, e;
  int   checks = 0;
  int   failures = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .IllegalInstr(IllegalInstr), .StateOut(StateOut)
  );

  always #10 clk = ~clk;

  function automatic exp_t mk(logic [3:0] st, logic pcw, logic irw, logic mw, logic rw,
                              logic [1:0] rs, logic [1:0] asa, logic [1:0] asb,
                              logic [1:0] imm, logic [3:0] alu, logic ill, logic adr);
    return {st, pcw, irw, mw, rw, rs, asa, asb, imm, alu, ill, adr};
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.st = StateOut;  s.pcw = PCWrite;   s.irw = IRWrite;  s.mw = MemWrite;
    s.rw = RegWrite;  s.rs = ResultSrc;  s.asa = ALUSrcA;  s.asb = ALUSrcB;
    s.imm = ImmSrc;   s.alu = ALUControl; s.ill = IllegalInstr; s.adr = AdrSrc;
    return s;
  endfunction

  // Expected control word for each state, written straight from the state table.
  function automatic exp_t e_fetch(logic r, logic [1:0] i);
    return mk(S_FETCH, r, r, 0, 0, 2'b10, 2'b00, 2'b10, i, 4'd0, 0, 0);
  endfunction
  function automatic exp_t e_decode(logic [1:0] i, logic ill);
    return mk(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, i, 4'd0, ill, 0);
  endfunction
  function automatic exp_t e_memadr(logic [1:0] i);
    return mk(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, i, 4'd0, 0, 0);
  endfunction
  function automatic exp_t e_memread(logic [1:0] i);
    return mk(S_MEMREAD, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, i, 4'd0, 0, 1);
  endfunction
  function automatic exp_t e_memwb(logic [1:0] i);
    return mk(S_MEMWB, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, i, 4'd0, 0, 0);
  endfunction
  function automatic exp_t e_memwrite(logic [1:0] i);
    return mk(S_MEMWRITE, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, i, 4'd0, 0, 1);
  endfunction
  function automatic exp_t e_exec(logic r_type, logic [1:0] i, logic [3:0] alu);
    return mk(r_type ? S_EXECR : S_EXECI, 0, 0, 0, 0, 2'b00, 2'b10, r_type ? 2'b00 : 2'b01, i, alu, 0, 0);
  endfunction
  function automatic exp_t e_aluwb(logic [1:0] i);
    return mk(S_ALUWB, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, i, 4'd0, 0, 0);
  endfunction
  function automatic exp_t e_branch(logic pcw);
    return mk(S_BRANCH, pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'd1, 0, 0);
  endfunction

  function automatic void push(exp_t x, logic r);
    exp_q.push_back(x);
    rdy_q.push_back(r);
  endfunction

  // Async reset from MEMREAD with MemReady low, enables gated while held, then a clean lw.
  task automatic test_reset();
    reset = 1'b0; MemReady = 1'b1; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    #3;
    push(e_fetch(1'b0, 2'b00), 1'b1);
    obs = sample(); e = exp_q.pop_front(); void'(rdy_q.pop_front()); checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL reset_held: got %h expected %h", obs, e); end
    #2 reset = 1'b1;
    #2;
    push(e_fetch(1'b1, 2'b00), 1'b1);
    obs = sample(); e = exp_q.pop_front(); void'(rdy_q.pop_front()); checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL reset_release: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    push(e_decode(2'b00, 1'b0), 1'b1); push(e_memadr(2'b00), 1'b1);
    push(e_memread(2'b00), 1'b0);      push(e_memread(2'b00), 1'b0);
    while (exp_q.size() > 0) begin
      MemReady = rdy_q.pop_front();
      @(negedge clk);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("[TB] FAIL reset_pre_abort: got %h expected %h", obs, e); end
      @(posedge clk); #1;
    end
    #4 MemReady = 1'b1; reset = 1'b0;
    #2;
    push(e_fetch(1'b0, 2'b00), 1'b1);
    obs = sample(); e = exp_q.pop_front(); void'(rdy_q.pop_front()); checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL reset_abort: got %h expected %h", obs, e); end
    #4 reset = 1'b1;
    #2;
    push(e_fetch(1'b1, 2'b00), 1'b1);
    obs = sample(); e = exp_q.pop_front(); void'(rdy_q.pop_front()); checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL reset_refetch: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    push(e_decode(2'b00, 1'b0), 1'b1); push(e_memadr(2'b00), 1'b1);
    push(e_memread(2'b00), 1'b1);      push(e_memwb(2'b00), 1'b1);
    while (exp_q.size() > 0) begin
      MemReady = rdy_q.pop_front();
      @(negedge clk);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("[TB] FAIL reset_resume: got %h expected %h", obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    op = LW; funct3 = 3'b010;
    push(e_fetch(1'b1, 2'b00), 1'b1); push(e_decode(2'b00, 1'b0), 1'b1);
    push(e_memadr(2'b00), 1'b1);      push(e_memread(2'b00), 1'b1);
    push(e_memwb(2'b00), 1'b1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      MemReady = rdy_q.pop_front();
      @(negedge clk);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("[TB] FAIL lw cycle %0d: got %h expected %h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    op = SW; funct3 = 3'b010;
    push(e_fetch(1'b1, 2'b01), 1'b1); push(e_decode(2'b01, 1'b0), 1'b1);
    push(e_memadr(2'b01), 1'b1);
    for (int k = 0; k < 3; k++) push(e_memwrite(2'b01), 1'b0);
    push(e_memwrite(2'b01), 1'b1);
    push(e_fetch(1'b0, 2'b01), 1'b0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      MemReady = rdy_q.pop_front();
      @(negedge clk);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("[TB] FAIL sw cycle %0d: got %h expected %h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3_t [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
    logic       z_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       pc_t [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    op = BR;
    for (int n = 0; n < 4; n++) begin
      funct3 = f3_t[n]; Zero = z_t[n];
      push(e_fetch(1'b1, 2'b10), 1'b1); push(e_decode(2'b10, 1'b0), 1'b1);
      push(e_branch(pc_t[n]), 1'b1);
      for (int c = 0; exp_q.size() > 0; c++) begin
        MemReady = rdy_q.pop_front();
        @(negedge clk);
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("[TB] FAIL branch%0d cycle %0d: got %h expected %h", n, c, obs, e); end
        @(posedge clk); #1;
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_funct();
    logic [6:0] op_t  [6] = '{RT, IT, IT, RT, RT, IT};
    logic [2:0] f3_t  [6] = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b111, 3'b010};
    logic       f7_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] alu_t [6] = '{4'b0001, 4'b0000, 4'b1000, 4'b0111, 4'b0010, 4'b0101};
    for (int n = 0; n < 6; n++) begin
      op = op_t[n]; funct3 = f3_t[n]; funct7b5 = f7_t[n];
      push(e_fetch(1'b1, 2'b00), 1'b1); push(e_decode(2'b00, 1'b0), 1'b1);
      push(e_exec(op_t[n] == RT, 2'b00, alu_t[n]), 1'b1);
      push(e_aluwb(2'b00), 1'b1);
      for (int c = 0; exp_q.size() > 0; c++) begin
        MemReady = rdy_q.pop_front();
        @(negedge clk);
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("[TB] FAIL funct%0d cycle %0d: got %h expected %h", n, c, obs, e); end
        @(posedge clk); #1;
      end
    end
    funct7b5 = 1'b0;
  endtask

  task automatic test_jal();
    op = JL; funct3 = 3'b000;
    push(e_fetch(1'b1, 2'b11), 1'b1); push(e_decode(2'b11, 1'b0), 1'b1);
    push(mk(S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 4'd0, 0, 0), 1'b1);
    push(e_aluwb(2'b11), 1'b1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      MemReady = rdy_q.pop_front();
      @(negedge clk);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("[TB] FAIL jal cycle %0d: got %h expected %h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    op = BAD; funct3 = 3'b000;
    push(e_fetch(1'b1, 2'b00), 1'b1); push(e_decode(2'b00, 1'b1), 1'b1);
    push(e_fetch(1'b0, 2'b00), 1'b0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      MemReady = rdy_q.pop_front();
      @(negedge clk);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("[TB] FAIL illegal cycle %0d: got %h expected %h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_branch();
    test_funct();
    test_jal();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
